// File: rtl/fifo_rd_packer_if.sv
// Signal bundle between the FIFO read port, the packer and the wide-word consumer.
// The slave modport is the packer's view; the master modport is the surrounding logic.
interface fifo_rd_packer_if #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4,
  parameter int CNT_W = $clog2(PACK + 1)
);
  logic                    fifo_empty_i;
  logic [WIDTH-1:0]        fifo_rdata_i;
  logic                    fifo_rd_en_o;
  logic                    flush_i;
  logic [WIDTH*PACK-1:0]   word_o;
  logic [CNT_W-1:0]        word_bytes_o;
  logic                    word_valid_o;
  logic                    word_ready_i;
  logic [15:0]             word_cnt_o;

  modport slave (
    input  fifo_empty_i, fifo_rdata_i, flush_i, word_ready_i,
    output fifo_rd_en_o, word_o, word_bytes_o, word_valid_o, word_cnt_o
  );

  modport master (
    output fifo_empty_i, fifo_rdata_i, flush_i, word_ready_i,
    input  fifo_rd_en_o, word_o, word_bytes_o, word_valid_o, word_cnt_o
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Drains a registered-read FIFO and packs PACK entries (first entry in the low lane) into a
// wide word held on a valid/ready handshake; a flush emits whatever lanes are already filled.
module fifo_rd_packer #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4,
  parameter int CNT_W = $clog2(PACK + 1)
) (
  input  logic            clk_i,
  input  logic            clr_i,
  fifo_rd_packer_if.slave bus
);
  typedef enum logic {ST_FILL, ST_HOLD} state_t;

  localparam logic [CNT_W:0]   PACK_EXT  = (CNT_W + 1)'(PACK);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PACK - 1);

  state_t                r_state, w_state_next;
  logic [CNT_W-1:0]      r_cnt, w_cnt_next, w_cap_cnt;
  logic                  r_pend;
  logic                  r_flush_pend, w_flush_pend_next;
  logic [WIDTH*PACK-1:0] r_word, w_word_load;
  logic [CNT_W-1:0]      r_bytes;
  logic                  r_valid, w_valid_next;
  logic                  w_load, w_rd_en;
  logic [15:0]           r_word_cnt, w_word_cnt_next;
  logic [CNT_W:0]        w_inflight;

  // Entries already captured plus the one whose data arrives this cycle.
  assign w_inflight = {1'b0, r_cnt} + {{CNT_W{1'b0}}, r_pend};
  assign w_cap_cnt  = r_cnt + CNT_W'(r_pend);
  assign w_rd_en    = !clr_i && (r_state == ST_FILL) && !bus.fifo_empty_i &&
                      !r_flush_pend && (w_inflight < PACK_EXT);

  generate
    for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
      logic [WIDTH-1:0] r_lane;
      logic             w_hit;
      logic [WIDTH-1:0] w_lane_cur;

      assign w_hit      = r_pend && (r_cnt == CNT_W'(gi));
      assign w_lane_cur = w_hit ? bus.fifo_rdata_i : r_lane;
      // Lanes beyond the captured count go out as zero on a partial word.
      assign w_word_load[gi*WIDTH +: WIDTH] = (CNT_W'(gi) < w_cap_cnt) ? w_lane_cur : '0;

      always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
          r_lane <= '0;
        end else if (w_hit) begin
          r_lane <= bus.fifo_rdata_i;
        end
      end
    end
  endgenerate

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = w_cap_cnt;
    w_flush_pend_next = r_flush_pend;
    w_valid_next      = r_valid;
    w_word_cnt_next   = r_word_cnt;
    w_load            = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (r_pend && (r_cnt == LAST_LANE)) begin
          w_load            = 1'b1;
          w_flush_pend_next = 1'b0;
        end else if (r_flush_pend && !r_pend) begin
          w_flush_pend_next = 1'b0;
          w_load            = (r_cnt != '0);
        end else if (bus.flush_i) begin
          w_flush_pend_next = 1'b1;
        end
        if (w_load) begin
          w_valid_next = 1'b1;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_valid && bus.word_ready_i) begin
          w_valid_next    = 1'b0;
          w_cnt_next      = '0;
          w_word_cnt_next = r_word_cnt + 16'd1;
          w_state_next    = ST_FILL;
        end
      end
      default: w_state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      r_state      <= ST_FILL;
      r_cnt        <= '0;
      r_pend       <= 1'b0;
      r_flush_pend <= 1'b0;
      r_word       <= '0;
      r_bytes      <= '0;
      r_valid      <= 1'b0;
      r_word_cnt   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_pend       <= w_rd_en;
      r_flush_pend <= w_flush_pend_next;
      r_valid      <= w_valid_next;
      r_word_cnt   <= w_word_cnt_next;
      if (w_load) begin
        r_word  <= w_word_load;
        r_bytes <= w_cap_cnt;
      end
    end
  end

  assign bus.fifo_rd_en_o = w_rd_en;
  assign bus.word_o       = r_word;
  assign bus.word_bytes_o = r_bytes;
  assign bus.word_valid_o = r_valid;
  assign bus.word_cnt_o   = r_word_cnt;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a small registered-read FIFO model feeds the packer and
// each scenario compares the packed words, counts and read pulses against hand-computed values.
module tb_fifo_rd_packer;
  localparam int WIDTH = 8;
  localparam int PACK  = 4;
  localparam int CNT_W = $clog2(PACK + 1);

  logic clk_i = 1'b0;
  logic clr_i = 1'b1;
  int   checks = 0;
  int   failures = 0;

  fifo_rd_packer_if #(.WIDTH(WIDTH), .PACK(PACK), .CNT_W(CNT_W)) bus ();

  fifo_rd_packer #(.WIDTH(WIDTH), .PACK(PACK), .CNT_W(CNT_W)) dut (
    .clk_i (clk_i),
    .clr_i (clr_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // FIFO model: data is registered and appears the cycle after an accepted read.
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  logic [7:0] rdata_r = 8'd0;
  int         rd_pulses = 0;
  int         rd_errs = 0;

  assign bus.fifo_empty_i = (wr_ptr == rd_ptr);
  assign bus.fifo_rdata_i = rdata_r;

  always @(posedge clk_i) begin
    if (bus.fifo_rd_en_o) begin
      if (wr_ptr == rd_ptr) begin
        rd_errs <= rd_errs + 1;
      end else begin
        rdata_r   <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 8'd1;
        rd_pulses <= rd_pulses + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s obs=0x%0h", tag, obs);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!bus.word_valid_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, 32'(bus.word_valid_o), 32'd1);
  endtask

  initial begin
    int first, vcyc, nrd, nval, stable;
    logic [31:0] vword;
    logic [31:0] vbytes;

    bus.flush_i      = 1'b0;
    bus.word_ready_i = 1'b0;

    // Reset state, with data already sitting in the FIFO.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_rd_en", 32'(bus.fifo_rd_en_o), 32'd0);
    chk("rst_word", bus.word_o, 32'd0);
    chk("rst_bytes", 32'(bus.word_bytes_o), 32'd0);
    chk("rst_valid", 32'(bus.word_valid_o), 32'd0);
    chk("rst_cnt", 32'(bus.word_cnt_o), 32'd0);

    // Full word with ready held high: latency and single-cycle valid.
    step();
    clr_i = 1'b0;
    bus.word_ready_i = 1'b1;
    first = -1; vcyc = -1; nrd = 0; nval = 0; vword = '0; vbytes = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (bus.fifo_rd_en_o) begin
        nrd++;
        if (first < 0) first = i;
      end
      if (bus.word_valid_o) begin
        nval++;
        vcyc   = i;
        vword  = bus.word_o;
        vbytes = 32'(bus.word_bytes_o);
      end
    end
    chk("t1_reads", 32'(nrd), 32'd4);
    chk("t1_first_rd", 32'(first), 32'd0);
    chk("t1_latency", 32'(vcyc - first), 32'd5);
    chk("t1_valid_cycles", 32'(nval), 32'd1);
    chk("t1_word", vword, 32'h44332211);
    chk("t1_bytes", vbytes, 32'd4);
    chk("t1_wcnt", 32'(bus.word_cnt_o), 32'd1);
    chk("t1_fifo_pops", 32'(rd_pulses), 32'd4);

    // Back-pressure: first word held stable, no reads while holding.
    step();
    bus.word_ready_i = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_valid("t2_w1_valid", 20);
    chk("t2_w1_word", bus.word_o, 32'h04030201);
    chk("t2_w1_bytes", 32'(bus.word_bytes_o), 32'd4);
    stable = 1; nrd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (bus.word_o !== 32'h04030201 || !bus.word_valid_o) stable = 0;
      if (bus.fifo_rd_en_o) nrd++;
    end
    chk("t2_hold_stable", 32'(stable), 32'd1);
    chk("t2_hold_reads", 32'(nrd), 32'd0);
    step();
    bus.word_ready_i = 1'b1;
    step();
    wait_valid("t2_w2_valid", 20);
    chk("t2_w2_word", bus.word_o, 32'h08070605);
    step();
    @(negedge clk_i);
    chk("t2_wcnt", 32'(bus.word_cnt_o), 32'd3);

    // Flush while the second read is in flight.
    step();
    push(8'hAA); push(8'hBB);
    step();
    step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    wait_valid("t3_valid", 10);
    chk("t3_word", bus.word_o, 32'h0000BBAA);
    chk("t3_bytes", 32'(bus.word_bytes_o), 32'd2);
    step();
    // Flush with nothing captured emits nothing.
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    nval = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (bus.word_valid_o) nval++;
    end
    chk("t3_empty_flush", 32'(nval), 32'd0);
    chk("t3_wcnt", 32'(bus.word_cnt_o), 32'd4);

    // FIFO runs dry after three entries; the fourth arrives much later.
    step();
    push(8'h31); push(8'h32); push(8'h33);
    nrd = 0; nval = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (bus.fifo_rd_en_o) nrd++;
      if (bus.word_valid_o) nval++;
    end
    chk("t4_reads", 32'(nrd), 32'd3);
    chk("t4_no_word", 32'(nval), 32'd0);
    step();
    push(8'h34);
    wait_valid("t4_valid", 10);
    chk("t4_word", bus.word_o, 32'h34333231);
    chk("t4_bytes", 32'(bus.word_bytes_o), 32'd4);
    chk("t4_rd_err", 32'(rd_errs), 32'd0);
    step();

    // Asynchronous reset with cnt=2 and a read in flight.
    push(8'hC1); push(8'hC2); push(8'hC3);
    step();
    step();
    step();
    #2;
    clr_i = 1'b1;
    #1;
    chk("t5_word", bus.word_o, 32'd0);
    chk("t5_bytes", 32'(bus.word_bytes_o), 32'd0);
    chk("t5_valid", 32'(bus.word_valid_o), 32'd0);
    chk("t5_wcnt", 32'(bus.word_cnt_o), 32'd0);
    chk("t5_rd_en", 32'(bus.fifo_rd_en_o), 32'd0);
    step();
    clr_i = 1'b0;
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    wait_valid("t5_valid_after", 12);
    chk("t5_word_after", bus.word_o, 32'hD4D3D2D1);
    step();
    @(negedge clk_i);
    chk("t5_wcnt_after", 32'(bus.word_cnt_o), 32'd1);

    // Word counter wrap, starting two handoffs short of the top.
    step();
    force dut.r_word_cnt = 16'hFFFE;
    #1;
    release dut.r_word_cnt;
    for (int i = 1; i <= 8; i++) push(8'(8'hE0 + 8'(i)));
    wait_valid("t6_w1_valid", 12);
    chk("t6_w1_word", bus.word_o, 32'hE4E3E2E1);
    step();
    @(negedge clk_i);
    chk("t6_wcnt_top", 32'(bus.word_cnt_o), 32'h0000FFFF);
    wait_valid("t6_w2_valid", 12);
    chk("t6_w2_word", bus.word_o, 32'hE8E7E6E5);
    step();
    @(negedge clk_i);
    chk("t6_wcnt_wrap", 32'(bus.word_cnt_o), 32'd0);
    chk("t6_rd_err", 32'(rd_errs), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
